// File: rtl/muldiv_pkg.sv
// Shared opcodes, FSM encoding and iteration-count helper for the multi-cycle
// multiply/divide engine.
package muldiv_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int cycles(input int xlen, input int bpc);
      return xlen / bpc;
   endfunction

endpackage

// File: rtl/muldiv_sign.sv
// Sign handling around the unsigned iteration core: magnitudes on entry,
// negation of product / quotient / remainder on exit.
module muldiv_sign
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic              sgn_entry,
   input  logic [XLEN-1:0]   a,
   input  logic [XLEN-1:0]   b,
   output logic [XLEN-1:0]   mag_a,
   output logic [XLEN-1:0]   mag_b,
   input  logic              is_div,
   input  logic              sign_a,
   input  logic              sign_b,
   input  logic [2*XLEN-1:0] raw,
   output logic [XLEN-1:0]   hi,
   output logic [XLEN-1:0]   lo
);

   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo;
   logic [XLEN-1:0]   rem;

   always_comb begin
      mag_a = (sgn_entry && a[XLEN-1]) ? -a : a;
      mag_b = (sgn_entry && b[XLEN-1]) ? -b : b;
      // sign_a/sign_b are already zero for unsigned ops, so no fix-up happens there
      prod  = (sign_a ^ sign_b) ? -raw : raw;
      quo   = (sign_a ^ sign_b) ? -raw[XLEN-1:0] : raw[XLEN-1:0];
      rem   = sign_a ? -raw[2*XLEN-1:XLEN] : raw[2*XLEN-1:XLEN];
      if (is_div) begin
         hi = rem;
         lo = quo;
      end else begin
         hi = prod[2*XLEN-1:XLEN];
         lo = prod[XLEN-1:0];
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine: shift-add multiply and restoring
// divide retiring BPC result bits per cycle, writing HI/LO on completion.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int BPC  = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic [1:0]      op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   input  logic            cancel_i,
   output logic            busy_o,
   output logic            done_o,
   output logic            whi_o,
   output logic            wlo_o,
   output logic [XLEN-1:0] hi_o,
   output logic [XLEN-1:0] lo_o,
   output logic            div_zero_o
);

   localparam int NCYC = cycles(XLEN, BPC);
   localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
   localparam logic [CW-1:0] LAST = CW'(NCYC - 1);

   state_t            state, state_next;
   logic [CW-1:0]     cnt;
   logic [2*XLEN-1:0] acc, acc_next;
   logic [XLEN-1:0]   oper;
   logic              is_div, sign_a, sign_b;
   logic [XLEN-1:0]   mag_a, mag_b, res_hi, res_lo;
   logic              signed_in, div_zero_in;
   logic [XLEN:0]     sum;

   assign signed_in   = ~op_i[0];
   assign div_zero_in = op_i[1] && (b_i == '0);
   assign busy_o      = (state != IDLE);
   assign whi_o       = done_o;
   assign wlo_o       = done_o;

   muldiv_sign #(.XLEN(XLEN)) u_sign (
      .sgn_entry (signed_in),
      .a         (a_i),
      .b         (b_i),
      .mag_a     (mag_a),
      .mag_b     (mag_b),
      .is_div    (is_div),
      .sign_a    (sign_a),
      .sign_b    (sign_b),
      .raw       (acc_next),
      .hi        (res_hi),
      .lo        (res_lo)
   );

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start_i) state_next = div_zero_in ? DONE : CALC;
         CALC: begin
            if (cancel_i)         state_next = IDLE;
            else if (cnt == LAST) state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Multiply keeps {partial product, multiplier}; divide keeps {remainder, dividend/quotient}.
   always_comb begin
      acc_next = acc;
      sum      = '0;
      for (int i = 0; i < BPC; i++) begin
         if (!is_div) begin
            sum      = {1'b0, acc_next[2*XLEN-1:XLEN]} + (acc_next[0] ? {1'b0, oper} : '0);
            acc_next = {sum, acc_next[XLEN-1:1]};
         end else begin
            sum = acc_next[2*XLEN-1:XLEN-1] - {1'b0, oper};
            if (!sum[XLEN]) acc_next = {sum[XLEN-1:0], acc_next[XLEN-2:0], 1'b1};
            else            acc_next = {acc_next[2*XLEN-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (state == IDLE && start_i) begin
         is_div <= op_i[1];
         sign_a <= signed_in & a_i[XLEN-1];
         sign_b <= signed_in & b_i[XLEN-1];
         oper   <= op_i[1] ? mag_b : mag_a;
         acc    <= {{XLEN{1'b0}}, (op_i[1] ? mag_a : mag_b)};
      end else if (state == CALC) begin
         acc <= acc_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt        <= '0;
         done_o     <= 1'b0;
         div_zero_o <= 1'b0;
         hi_o       <= '0;
         lo_o       <= '0;
      end else begin
         done_o     <= (state_next == DONE);
         div_zero_o <= (state == IDLE) && start_i && div_zero_in;
         if (state == IDLE) begin
            cnt <= '0;
            if (start_i && div_zero_in) begin
               hi_o <= a_i;
               lo_o <= '1;
            end
         end else if (state == CALC) begin
            cnt <= cnt + 1'b1;
            if (!cancel_i && cnt == LAST) begin
               hi_o <= res_hi;
               lo_o <= res_lo;
            end
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: BPC=1 and BPC=2 instances share stimulus,
// each with its own expected-result queue.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start_i = 1'b0;
   logic        cancel_i = 1'b0;
   logic [1:0]  op_i = 2'b00;
   logic [31:0] a_i = '0;
   logic [31:0] b_i = '0;

   logic        busy1, done1, whi1, wlo1, dz1;
   logic [31:0] hi1, lo1;
   logic        busy2, done2, whi2, wlo2, dz2;
   logic [31:0] hi2, lo2;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      int          lat;
      int          start;
   } exp_t;

   exp_t q1[$];
   exp_t q2[$];
   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   logic [31:0] last_hi = '0;
   logic [31:0] last_lo = '0;

   muldiv_unit #(.XLEN(32), .BPC(1)) u_dut1 (
      .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
      .cancel_i(cancel_i), .busy_o(busy1), .done_o(done1), .whi_o(whi1), .wlo_o(wlo1),
      .hi_o(hi1), .lo_o(lo1), .div_zero_o(dz1)
   );

   muldiv_unit #(.XLEN(32), .BPC(2)) u_dut2 (
      .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
      .cancel_i(cancel_i), .busy_o(busy2), .done_o(done2), .whi_o(whi2), .wlo_o(wlo2),
      .hi_o(hi2), .lo_o(lo2), .div_zero_o(dz2)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
      n_cmp++;
      if (got !== expv) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, expv);
      end
   endtask

   function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      longint sa, sb;
      logic [63:0] p;
      e.hi = '0; e.lo = '0; e.dz = 1'b0; e.lat = 0; e.start = 0;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         2'b00: begin p = 64'(sa * sb); e.hi = p[63:32]; e.lo = p[31:0]; end
         2'b01: begin p = {32'b0, a} * {32'b0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
         default: begin
            if (b == 32'd0) begin
               e.hi = a; e.lo = 32'hFFFF_FFFF; e.dz = 1'b1;
            end else if (op == 2'b10) begin
               if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                  e.lo = 32'h8000_0000; e.hi = 32'h0;
               end else begin
                  e.lo = 32'(sa / sb); e.hi = 32'(sa % sb);
               end
            end else begin
               e.lo = a / b; e.hi = a % b;
            end
         end
      endcase
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (rst && done1 === 1'b1) begin
         if (q1.size() == 0) chk("u1_unexpected_done", 64'(done1), 64'd0);
         else begin
            e = q1.pop_front();
            chk("u1_hi", 64'(hi1), 64'(e.hi));
            chk("u1_lo", 64'(lo1), 64'(e.lo));
            chk("u1_div_zero", 64'(dz1), 64'(e.dz));
            chk("u1_whi_wlo", 64'({whi1, wlo1}), 64'd3);
            chk("u1_latency", 64'(cyc - e.start + 1), 64'(e.lat));
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst && done2 === 1'b1) begin
         if (q2.size() == 0) chk("u2_unexpected_done", 64'(done2), 64'd0);
         else begin
            e = q2.pop_front();
            chk("u2_hi", 64'(hi2), 64'(e.hi));
            chk("u2_lo", 64'(lo2), 64'(e.lo));
            chk("u2_div_zero", 64'(dz2), 64'(e.dz));
            chk("u2_whi_wlo", 64'({whi2, wlo2}), 64'd3);
            chk("u2_latency", 64'(cyc - e.start + 1), 64'(e.lat));
         end
      end
   end

   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit push);
      exp_t e;
      @(negedge clk);
      e = model(op, a, b);
      e.start = cyc + 1;
      if (push) begin
         e.lat = e.dz ? 1 : 33;
         q1.push_back(e);
         e.lat = e.dz ? 1 : 17;
         q2.push_back(e);
         last_hi = e.hi;
         last_lo = e.lo;
      end
      start_i = 1'b1; op_i = op; a_i = a; b_i = b;
      @(negedge clk);
      start_i = 1'b0; a_i = $urandom; b_i = $urandom; op_i = 2'($urandom_range(0, 3));
   endtask

   task automatic wait_done();
      int t = 0;
      while ((q1.size() != 0 || q2.size() != 0) && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) begin
         chk("done_timeout", 64'(q1.size() + q2.size()), 64'd0);
         q1.delete();
         q2.delete();
      end
      @(negedge clk);
      chk("pulse_ended", 64'({done1, whi1, wlo1, done2, whi2, wlo2, busy1, busy2}), 64'd0);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   logic [1:0]  vop[10] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b00, 2'b10, 2'b10, 2'b01};
   logic [31:0] va[10]  = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd100, 32'h1234_5678,
                            32'h8000_0000, 32'h8000_0000, 32'hFFFF_FF9C, 32'd5, 32'd0};
   logic [31:0] vb[10]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd2, 32'd7, 32'd0,
                            32'hFFFF_FFFF, 32'h8000_0000, 32'd7, 32'd0, 32'hDEAD_BEEF};

   initial begin
      idle(3);
      chk("reset_state_u1", 64'({busy1, done1, whi1, wlo1, dz1, hi1, lo1}), 64'd0);
      chk("reset_state_u2", 64'({busy2, done2, whi2, wlo2, dz2, hi2, lo2}), 64'd0);
      rst = 1'b1;
      idle(2);

      for (int i = 0; i < 10; i++) begin
         issue(vop[i], va[i], vb[i], 1'b1);
         wait_done();
      end

      // synchronous reset while both units are iterating
      issue(2'b01, 32'h0000_1234, 32'h0000_5678, 1'b0);
      idle(9);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      chk("rst_mid_calc_u1", 64'({busy1, done1, hi1, lo1}), 64'd0);
      chk("rst_mid_calc_u2", 64'({busy2, done2, hi2, lo2}), 64'd0);
      idle(40);

      issue(2'b11, 32'd1000, 32'd33, 1'b1);
      wait_done();

      // cancel mid-CALC: no write, HI/LO keep the last result
      issue(2'b00, 32'h0001_0000, 32'h0003_0000, 1'b0);
      idle(4);
      cancel_i = 1'b1;
      @(negedge clk);
      cancel_i = 1'b0;
      idle(40);
      chk("cancel_hold_u1", 64'({busy1, hi1, lo1}), 64'({1'b0, last_hi, last_lo}));
      chk("cancel_hold_u2", 64'({busy2, hi2, lo2}), 64'({1'b0, last_hi, last_lo}));

      // a second start while busy is ignored
      issue(2'b10, 32'hFFFF_0000, 32'd3, 1'b1);
      idle(2);
      start_i = 1'b1; op_i = 2'b01; a_i = 32'd9; b_i = 32'd9;
      @(negedge clk);
      start_i = 1'b0;
      wait_done();

      for (int i = 0; i < 6; i++) begin
         issue(2'($urandom_range(0, 3)), $urandom, (i == 5) ? 32'd0 : $urandom, 1'b1);
         wait_done();
      end

      idle(5);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
